// File: rtl/dsram_pkg.sv
// Shared types and constants for the SRAM-like data-side responder.
package dsram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DSRAM_QDEPTH = 2;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } q_entry_t;

endpackage

// File: rtl/data_sram_like_slave_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), used for random stall/delay injection.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk) begin
    if (reset)   q <= 16'hACE1;
    else if (en) q <= {q[14:0], fb};
  end

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like responder: word memory behind a 2-entry in-order response queue.
// Optional random stalls/extra latency when DSRAM_RAND_DELAY_EN is defined.
module data_sram_like_slave
  import dsram_pkg::*;
#(
  parameter int AW      = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  logic [31:0]             mem [2**AW];
  q_entry_t                slot [DSRAM_QDEPTH];
  logic [DSRAM_QDEPTH-1:0] slot_vld;
  logic                    head;
  logic                    tail;
  logic [1:0]              count;
  logic                    stall;
  logic [1:0]              extra;
  logic                    accept;
  logic                    pop;
  logic [AW-1:0]           widx;
  logic [3:0]              cnt_init;
  logic                    unused_bits;

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr)
  );

  assign stall       = (lfsr[1:0] == 2'b11);
  assign extra       = lfsr[3:2];
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0], lfsr[15:4]};
`else
  assign stall       = 1'b0;
  assign extra       = 2'b00;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};
`endif

  // Full queue blocks acceptance even when the head pops this cycle.
  assign data_sram_addr_ok = ~reset & (count != 2'(DSRAM_QDEPTH)) & ~stall;
  assign data_sram_data_ok = slot_vld[head] && (slot[head].cnt == 4'd0);
  assign data_sram_rdata   = (data_sram_data_ok && !slot[head].wr) ? slot[head].data : 32'd0;

  assign accept   = data_sram_req & data_sram_addr_ok;
  assign pop      = data_sram_data_ok;
  assign widx     = data_sram_addr[AW+1:2];
  assign cnt_init = 4'(LATENCY - 1) + {2'b00, extra};

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < DSRAM_QDEPTH; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < DSRAM_QDEPTH; i++) begin
        if (slot_vld[i] && slot[i].cnt != 4'd0) slot[i].cnt <= slot[i].cnt - 4'd1;
      end
      if (pop) begin
        slot_vld[head] <= 1'b0;
        head           <= ~head;
      end
      // Loads capture memory here; earlier stores are already visible.
      if (accept) begin
        slot[tail].wr   <= data_sram_wr;
        slot[tail].data <= data_sram_wr ? 32'd0 : mem[widx];
        slot[tail].cnt  <= cnt_init;
        slot_vld[tail]  <= 1'b1;
        tail            <= ~tail;
      end
      count <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed self-checking bench; three DUT instances at LATENCY 1, 3 and 4.
module tb_data_sram_like_slave;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic        req1, req3, req4;
  logic        ao1, ao3, ao4;
  logic        do1, do3, do4;
  logic [31:0] rd1, rd3, rd4;

  int checks = 0;
  int errors = 0;

  data_sram_like_slave #(.AW(12), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .data_sram_req(req1), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_addr(addr), .data_sram_wstrb(strb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(ao1), .data_sram_data_ok(do1), .data_sram_rdata(rd1));

  data_sram_like_slave #(.AW(12), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .data_sram_req(req3), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_addr(addr), .data_sram_wstrb(strb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(ao3), .data_sram_data_ok(do3), .data_sram_rdata(rd3));

  data_sram_like_slave #(.AW(12), .LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .data_sram_req(req4), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_addr(addr), .data_sram_wstrb(strb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(ao4), .data_sram_data_ok(do4), .data_sram_rdata(rd4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    wr    = w;
    addr  = a;
    strb  = s;
    wdata = d;
    size  = 2'b10;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ao1 !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b exp 0", ao1); end
    checks++; if (do1 !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b exp 0", do1); end
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rd1); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ao1 !== 1'b1) begin errors++; $display("FAIL post_reset_addr_ok got %b exp 1", ao1); end
    checks++; if (do1 !== 1'b0) begin errors++; $display("FAIL post_reset_data_ok got %b exp 0", do1); end
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL post_reset_rdata got %h exp 0", rd1); end
  endtask

  task automatic test_single();
    set_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF); req1 = 1'b1;
    @(posedge clk); #1;
    set_req(1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (do1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL single_store_resp got ok=%b rd=%h exp ok=1 rd=0", do1, rd1); end
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    checks++; if (do1 !== 1'b1 || rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_load_resp got ok=%b rd=%h exp ok=1 rd=deadbeef", do1, rd1); end
    @(negedge clk);
    checks++; if (do1 !== 1'b0) begin errors++; $display("FAIL single_idle got ok=%b exp 0", do1); end
  endtask

  task automatic test_byte_lanes();
    logic        w_t [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] a_t [8] = '{32'h20, 32'h22, 32'h20, 32'h21, 32'h20, 32'h20, 32'h20, 32'h4010};
    logic [3:0]  s_t [8] = '{4'hF, 4'h4, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [31:0] d_t [8] = '{32'h11223344, 32'h00AA0000, 32'h0, 32'h55667700, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] e_t [8] = '{32'h0, 32'h0, 32'h11AA3344, 32'h0, 32'h55667744, 32'h0, 32'h55667744, 32'hDEADBEEF};
    for (int i = 0; i < 8; i++) begin
      set_req(w_t[i], a_t[i], s_t[i], d_t[i]); req1 = 1'b1;
      @(posedge clk); #1 req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (do1 !== 1'b1 || rd1 !== e_t[i]) begin
        errors++; $display("FAIL byte_lanes[%0d] got ok=%b rd=%h exp ok=1 rd=%h", i, do1, rd1, e_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 32'h100 + 32'(i * 4), 4'hF, 32'hA0000000 + 32'(i) * 32'h01010101); req1 = 1'b1;
      @(posedge clk); #1 req1 = 1'b0;
      @(negedge clk);
      checks++; if (do1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL b2b_store[%0d] got ok=%b rd=%h exp ok=1 rd=0", i, do1, rd1); end
    end
    set_req(1'b0, 32'h100, 4'h0, 32'h0); req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) set_req(1'b0, 32'h100 + 32'((i + 1) * 4), 4'h0, 32'h0);
      else req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (do1 !== 1'b1 || ao1 !== 1'b1 || rd1 !== 32'hA0000000 + 32'(i) * 32'h01010101) begin
        errors++; $display("FAIL b2b_load[%0d] got ok=%b aok=%b rd=%h exp ok=1 aok=1 rd=%h", i, do1, ao1, rd1,
                           32'hA0000000 + 32'(i) * 32'h01010101);
      end
    end
    @(negedge clk);
    checks++; if (do1 !== 1'b0) begin errors++; $display("FAIL b2b_tail got ok=%b exp 0", do1); end
  endtask

  task automatic test_queue_full();
    logic [31:0] la [4] = '{32'h40, 32'h44, 32'h40, 32'h44};
    logic        ao_e [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        do_e [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_e [11] = '{32'h0, 32'h0, 32'h0, 32'h40404040, 32'h44444444, 32'h0, 32'h0, 32'h0,
                               32'h40404040, 32'h44444444, 32'h0};
    int   idx = 0;
    logic acc;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, la[i], 4'hF, (i == 0) ? 32'h40404040 : 32'h44444444); req4 = 1'b1;
      @(posedge clk); #1 req4 = 1'b0;
      repeat (5) @(negedge clk);
    end
    checks++; if (ao4 !== 1'b1) begin errors++; $display("FAIL qfull_start_aok got %b exp 1", ao4); end
    set_req(1'b0, la[0], 4'h0, 32'h0); req4 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      acc = req4 && ao4;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) addr = la[idx];
        else req4 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (ao4 !== ao_e[k] || do4 !== do_e[k] || rd4 !== rd_e[k]) begin
        errors++; $display("FAIL qfull_cycle[%0d] got aok=%b ok=%b rd=%h exp aok=%b ok=%b rd=%h",
                           k, ao4, do4, rd4, ao_e[k], do_e[k], rd_e[k]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_req(1'b1, 32'h80, 4'hF, 32'h80808080); req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    repeat (4) @(negedge clk);
    set_req(1'b0, 32'h80, 4'h0, 32'h0); req3 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ao3 !== 1'b1) begin errors++; $display("FAIL midflight_second_aok got %b exp 1", ao3); end
    @(posedge clk); #1 req3 = 1'b0; reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (ao3 !== 1'b0 || do3 !== 1'b0) begin errors++; $display("FAIL midflight_in_reset[%0d] got aok=%b ok=%b exp aok=0 ok=0", k, ao3, do3); end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (ao3 !== 1'b1 || do3 !== 1'b0) begin errors++; $display("FAIL midflight_after[%0d] got aok=%b ok=%b exp aok=1 ok=0", k, ao3, do3); end
    end
    set_req(1'b0, 32'h80, 4'h0, 32'h0); req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (do3 !== 1'b0) begin errors++; $display("FAIL midflight_early_ok got %b exp 0", do3); end
    @(negedge clk);
    checks++; if (do3 !== 1'b1 || rd3 !== 32'h80808080) begin errors++; $display("FAIL midflight_retained got ok=%b rd=%h exp ok=1 rd=80808080", do3, rd3); end
  endtask

`ifdef DSRAM_RAND_DELAY_EN
  task automatic test_random_delay();
    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    int          acc_q [$];
    int          cyc = 0, issued = 0, got = 0, lat;
    logic        acc;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    req1 = 1'b0;
    while ((issued < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      if (do1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious_ok at cycle %0d exp no response", cyc);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - acc_q.pop_front() + 1;
          got++;
          checks++; if (rd1 !== e) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", got, rd1, e); end
          checks++; if (lat < 1 || lat > 4) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp 1..4", got, lat); end
        end
      end
      acc = req1 && ao1;
      if (acc) begin
        issued++;
        if (wr) begin
          for (int b = 0; b < 4; b++) if (strb[b]) model[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
          exp_q.push_back(32'd0);
        end else exp_q.push_back(model[addr[5:2]]);
        acc_q.push_back(cyc + 1);
      end
      @(posedge clk); cyc++; #1;
      if (acc || !req1) begin
        if (issued < 1000 && $urandom_range(0, 3) != 0) begin
          if (issued < 16) set_req(1'b1, 32'(issued * 4), 4'hF, $urandom);
          else set_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), 4'($urandom_range(0, 15)), $urandom);
          req1 = 1'b1;
        end else req1 = 1'b0;
      end
    end
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout got %0d cycles exp < 20000", cyc); end
    checks++; if (got !== issued) begin errors++; $display("FAIL rand_count got %0d responses exp %0d", got, issued); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req1 = 1'b0; req3 = 1'b0; req4 = 1'b0;
    set_req(1'b0, 32'h0, 4'h0, 32'h0);
    test_reset();
`ifdef DSRAM_RAND_DELAY_EN
    test_random_delay();
`else
    test_single();
    test_byte_lanes();
    test_back_to_back();
    test_queue_full();
    test_reset_midflight();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
